fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage of the model computer, directly upstream of the opcode decoder.
//  - Owns the PC and reads instruction memory over a req/ack handshake.
//  - Latches the fetched word into the IR and presents the opcode and operand to the decoder
//    and execute stage.
//  - Computes the next PC from the decoder's 3-bit PC select code once execute reports done.
// PARAMETERS
//  PC_W      8       PC / instruction-memory address width
//  INSTR_W   16      instruction width; op = instr[INSTR_W-1 -: 4], operand = instr[INSTR_W-5:0]
//  RESET_PC  0       PC value loaded on reset (PC_W bits)
// PORTS
//  clk         in   1           rising-edge clock
//  rst         in   1           synchronous active-high reset
//  imem_req    out  1           read request to instruction memory
//  imem_addr   out  PC_W        read address (always equals pc)
//  imem_ack    in   1           read complete; imem_data valid this cycle
//  imem_data   in   INSTR_W     instruction word
//  op          out  4           IR opcode field, to decoder
//  operand     out  INSTR_W-4   IR operand field (immediate / branch offset)
//  instr_valid out  1           IR holds an instruction being executed (state EXEC)
//  pc          out  PC_W        current PC
//  pc_sel      in   3           next-PC select from decoder, sampled with exec_done
//  zero_flag   in   1           ALU zero flag, sampled with exec_done
//  carry_flag  in   1           ALU carry flag, sampled with exec_done
//  jr_target   in   PC_W        register value for jump-register
//  exec_done   in   1           execute stage finished current instruction
//  halt        in   1           stop after current instruction, sampled with exec_done
//  halted      out  1           state HALT
// BEHAVIOUR
//  States: FETCH, EXEC, HALT.
//  Reset (rst high at edge):
//   - state=FETCH, pc=RESET_PC, IR=0.
//   - imem_req=0 during the reset cycle and rises the first cycle after rst falls.
//   - instr_valid=0, halted=0.
//  FETCH:
//   - imem_req=1 with imem_addr=pc, held stable until imem_ack.
//   - Ack in the first req cycle (zero wait states) is legal.
//   - On ack: IR<=imem_data, state<=EXEC, req drops the next cycle.
//  EXEC:
//   - instr_valid=1; op/operand stable; imem_req=0.
//   - Held indefinitely until exec_done; multi-cycle execute is legal.
//   - On exec_done with halt=1: pc<=next_pc, state<=HALT.
//   - On exec_done with halt=0: pc<=next_pc, state<=FETCH.
//   - Minimum instruction period: 2 cycles (ack cycle plus exec_done cycle).
//  HALT:
//   - All handshake outputs 0; halted=1.
//   - Only rst exits HALT.
//  next_pc is selected by pc_sel; all arithmetic is modulo 2^PC_W, wrap silent:
//   - 000, 001: pc+1
//   - 010: operand[PC_W-1:0] (absolute jump)
//   - 011, 111: pc+1 (reserved codes)
//   - 100: zero_flag ? pc+1+sext(operand[PC_W-1:0]) : pc+1
//   - 101: carry_flag ? pc+1+sext(operand[PC_W-1:0]) : pc+1
//   - 110: jr_target (jump register)
//  Ignored inputs:
//   - imem_ack outside FETCH is ignored, as is a late ack after reset.
//   - exec_done outside EXEC is ignored.
//  Reset mid-handshake: req drops the same edge; no IR or pc update from an ack coincident
//  with rst.
//  IR holds its value through FETCH; op/operand remain those of the previous instruction
//  until the next ack.
// TESTING
//  1. RESET_PC=0, rst 2 cycles -> cycle after rst low: req=1, addr=00; ack after 2 waits with
//     16'h1234 -> next cycle op=1, operand=12'h234, instr_valid=1, req=0.
//  2. pc=8'hFF, pc_sel=000, exec_done -> next FETCH addr=8'h00 (wrap).
//  3. pc=8'h10, pc_sel=100, operand[7:0]=8'hFE:
//     - zero_flag=1 -> addr 8'h0F
//     - zero_flag=0 -> addr 8'h11
//     - repeat with 101 and carry_flag: same results.
//  4. pc_sel=010, operand=12'h0A5 -> addr 8'hA5; pc_sel=110, jr_target=8'h3C -> addr 8'h3C.
//  5. rst while req=1 awaiting ack, ack arrives next cycle -> ignored, pc=RESET_PC, IR=0;
//     exec_done pulsed in FETCH -> no pc change.
//  6. exec_done with halt=1 -> halted=1, req stays 0 for 20 cycles despite ack/exec_done
//     pulses; rst -> FETCH at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches over req/ack into the IR and steps the PC when execute completes
module fetch_unit #(
  parameter int PC_W = 8,
  parameter int INSTR_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [3:0]         op,
  output logic [INSTR_W-5:0] operand,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  input  logic [2:0]         pc_sel,
  input  logic               zero_flag,
  input  logic               carry_flag,
  input  logic [PC_W-1:0]    jr_target,
  input  logic               exec_done,
  input  logic               halt,
  output logic               halted
);
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
  state_t r_state, w_next;
  logic r_req, w_ack, w_done, w_br_take;
  logic [PC_W-1:0] r_pc, w_off, w_inc, w_next_pc;
  logic [INSTR_W-1:0] r_ir;
  // req is registered, so an ack in the cycle right after reset sees req=0 and is dropped
  assign w_ack = r_req & imem_ack;
  assign w_done = (r_state == EXEC) & exec_done;
  always_comb begin
    w_next = w_ack ? EXEC : w_done ? (halt ? HALT : FETCH) : r_state;
    w_off = operand[PC_W-1:0];
    w_inc = r_pc + 1'b1;
    w_br_take = (pc_sel == 3'b100 && zero_flag) || (pc_sel == 3'b101 && carry_flag);
    w_next_pc = pc_sel == 3'b010 ? w_off :
                pc_sel == 3'b110 ? jr_target :
                w_br_take ? w_inc + w_off : w_inc;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req <= 1'b0;
      r_pc <= RESET_PC;
      r_ir <= '0;
    end else begin
      r_req <= (w_next == FETCH);
      if (w_ack) r_ir <= imem_data;
      if (w_done) r_pc <= w_next_pc;
    end
  end
  assign imem_req = r_req;
  assign imem_addr = r_pc;
  assign pc = r_pc;
  assign op = r_ir[INSTR_W-1 -: 4];
  assign operand = r_ir[INSTR_W-5:0];
  assign instr_valid = (r_state == EXEC);
  assign halted = (r_state == HALT);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: drives fetch/execute transactions and checks them against a next-PC reference model
module tb_fetch_unit;
  logic clk = 0, rst = 1, imem_req, imem_ack = 0, instr_valid, zero_flag = 0, carry_flag = 0;
  logic exec_done = 0, halt = 0, halted;
  logic [7:0] imem_addr, pc, jr_target = 0, m_pc = 0;
  logic [15:0] imem_data = 0;
  logic [3:0] op;
  logic [11:0] operand;
  logic [2:0] pc_sel = 0;
  int errors = 0, checks = 0;
  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .op(op), .operand(operand), .instr_valid(instr_valid), .pc(pc),
    .pc_sel(pc_sel), .zero_flag(zero_flag), .carry_flag(carry_flag), .jr_target(jr_target),
    .exec_done(exec_done), .halt(halt), .halted(halted)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] ref_next(input logic [7:0] p, input logic [2:0] sel,
      input logic [11:0] opnd, input logic z, input logic c, input logic [7:0] jr);
    int off, t;
    off = opnd[7] ? int'(opnd[7:0]) - 256 : int'(opnd[7:0]);
    t = int'(p) + 1;
    if (sel == 3'd2) t = int'(opnd[7:0]);
    else if (sel == 3'd6) t = int'(jr);
    else if ((sel == 3'd4 && z) || (sel == 3'd5 && c)) t = int'(p) + 1 + off;
    return t[7:0];
  endfunction
  task automatic do_reset(input int n);
    rst = 1;
    repeat (n) @(negedge clk);
    rst = 0;
    m_pc = 0;
    chk("rst_state", {5'b0, imem_req, instr_valid, halted, pc, op, operand}, 32'h0);
  endtask
  task automatic instr(input int waits, input int ex, input logic [15:0] d, input logic [2:0] sel,
      input logic z, input logic c, input logic [7:0] jr, input logic h);
    int n = 0;
    while (!imem_req && n < 4) begin
      @(negedge clk);
      n++;
    end
    chk("req_rise", imem_req, 1);
    chk("addr", imem_addr, m_pc);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      chk("req_hold", {imem_req, imem_addr}, {1'b1, m_pc});
    end
    imem_ack = 1;
    imem_data = d;
    @(negedge clk);
    imem_ack = 0;
    imem_data = 16'($urandom);
    chk("ir", {imem_req, instr_valid, op, operand}, {2'b01, d});
    for (int i = 0; i < ex; i++) begin
      imem_ack = 1'($urandom);
      @(negedge clk);
      chk("exec_hold", {imem_req, instr_valid, op, operand, pc}, {2'b01, d, m_pc});
    end
    imem_ack = 0;
    pc_sel = sel;
    zero_flag = z;
    carry_flag = c;
    jr_target = jr;
    halt = h;
    exec_done = 1;
    @(negedge clk);
    exec_done = 0;
    halt = 0;
    m_pc = ref_next(m_pc, sel, d[11:0], z, c, jr);
    chk("next_pc", pc, m_pc);
    if (h) chk("halt_state", {imem_req, instr_valid, halted}, 3'b001);
    else chk("refetch", {imem_req, instr_valid, halted, imem_addr}, {3'b100, m_pc});
  endtask
  initial begin
    @(negedge clk);
    do_reset(2);
    instr(2, 0, 16'h1234, 3'b000, 0, 0, 0, 0);
    instr(0, 0, 16'h00FF, 3'b010, 0, 0, 0, 0);
    chk("abs_ff", pc, 8'hFF);
    instr(1, 1, 16'h7777, 3'b000, 0, 0, 0, 0);
    chk("wrap", pc, 8'h00);
    for (int s = 4; s <= 5; s++)
      for (int f = 1; f >= 0; f--) begin
        instr(0, 0, 16'h0010, 3'b010, 0, 0, 0, 0);
        instr(1, 2, 16'h20FE, 3'(s), s == 4 ? f[0] : ~f[0], s == 5 ? f[0] : ~f[0], 8'h99, 0);
        chk("branch", pc, f ? 8'h0F : 8'h11);
      end
    instr(0, 0, 16'h00A5, 3'b010, 0, 0, 0, 0);
    chk("jump_abs", pc, 8'hA5);
    instr(0, 0, 16'h5000, 3'b110, 0, 0, 8'h3C, 0);
    chk("jump_reg", pc, 8'h3C);
    for (int k = 0; k < 40; k++)
      instr($urandom_range(3), $urandom_range(3), 16'($urandom), 3'($urandom), 1'($urandom),
            1'($urandom), 8'($urandom), 0);
    instr(0, 0, 16'h0055, 3'b010, 0, 0, 0, 0);
    rst = 1;
    imem_ack = 1;
    imem_data = 16'hABCD;
    @(negedge clk);
    rst = 0;
    imem_data = 16'hBEEF;
    m_pc = 0;
    chk("rst_mid", {imem_req, instr_valid, pc, op, operand}, 26'h0);
    @(negedge clk);
    imem_ack = 0;
    chk("late_ack", {imem_req, instr_valid, pc, op, operand}, {2'b10, 24'h0});
    pc_sel = 3'b010;
    exec_done = 1;
    @(negedge clk);
    exec_done = 0;
    chk("done_in_fetch", {imem_req, instr_valid, pc}, {2'b10, 8'h00});
    instr(0, 1, 16'h9123, 3'b000, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'($urandom);
      exec_done = 1'($urandom);
      @(negedge clk);
      chk("halt_hold", {imem_req, instr_valid, halted, pc}, {3'b001, m_pc});
    end
    imem_ack = 0;
    exec_done = 0;
    do_reset(1);
    @(negedge clk);
    chk("restart", {imem_req, halted, imem_addr}, {2'b10, 8'h00});
    instr(0, 0, 16'h4321, 3'b000, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
